// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and default sizing for the data-memory port arbiter.
package dmem_port_arbiter_pkg;

  localparam int WORD_SIZE_P       = 16;
  localparam int DMEM_STARVE_LIMIT = 4;
  localparam int DMEM_STORE_Q_ELS  = 2;

  typedef struct packed {
    logic [WORD_SIZE_P-1:0] addr;
    logic [WORD_SIZE_P-1:0] data;
  } dmem_store_entry_s;

endpackage

// File: rtl/dmem_port_arbiter_store_queue.sv
// In-order committed-store FIFO; head entry is visible combinationally so it can
// be written to memory in the same cycle it is granted.
module dmem_store_queue
  import dmem_port_arbiter_pkg::*;
#(
  parameter int els_p   = DMEM_STORE_Q_ELS,
  parameter int width_p = $bits(dmem_store_entry_s)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enq_i,
  input  logic [width_p-1:0] data_i,
  input  logic               deq_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p + 1);

  if (els_p < 2 || (els_p & (els_p - 1)) != 0) begin : g_bad_depth
    $error("dmem_store_queue: els_p must be a power of 2 and at least 2");
  end

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wptr_q, rptr_q;
  logic [cnt_w_lp-1:0] count_q;
  logic                enq_ok, deq_ok;

  assign full_o  = (count_q == cnt_w_lp'(els_p));
  assign empty_o = (count_q == '0);
  assign enq_ok  = enq_i & ~full_o;
  assign deq_ok  = deq_i & ~empty_o;
  assign data_o  = mem_q[rptr_q];

  // Power-of-2 depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq_ok) wptr_q <= wptr_q + ptr_w_lp'(1);
      if (deq_ok) rptr_q <= rptr_q + ptr_w_lp'(1);
      count_q <= count_q + cnt_w_lp'(enq_ok) - cnt_w_lp'(deq_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq_ok) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between loads and buffered committed stores,
// with bounded store starvation and a one-cycle load response path.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int word_size_p    = WORD_SIZE_P,
  parameter int waddr_width_p  = $clog2(word_size_p),
  parameter int store_q_els_p  = DMEM_STORE_Q_ELS,
  parameter int starve_limit_p = DMEM_STARVE_LIMIT,
  parameter int tag_width_p    = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic                     st_v_i,
  input  logic [word_size_p-1:0]   st_addr_i,
  input  logic [word_size_p-1:0]   st_data_i,
  output logic                     st_ready_o,
  input  logic                     ld_v_i,
  input  logic [word_size_p-1:0]   ld_addr_i,
  input  logic [tag_width_p-1:0]   ld_tag_i,
  output logic                     ld_ready_o,
  output logic                     ld_resp_v_o,
  output logic [word_size_p-1:0]   ld_resp_data_o,
  output logic [tag_width_p-1:0]   ld_resp_tag_o,
  output logic                     data_mem_w_v_i,
  output logic [waddr_width_p-1:0] data_mem_w_addr_i,
  output logic [word_size_p-1:0]   data_mem_w_data_i,
  output logic                     data_mem_r_v_i,
  output logic [word_size_p-1:0]   data_mem_r_addr_i,
  input  logic [word_size_p-1:0]   data_mem_r_data_o
);

  localparam int cnt_w_lp   = $clog2(starve_limit_p + 1);
  localparam int entry_w_lp = waddr_width_p + word_size_p;

  logic                   q_full, q_empty;
  logic [entry_w_lp-1:0]  q_head;
  logic                   force_store, store_wins, ld_issue, st_accept;
  logic [cnt_w_lp-1:0]    starve_q, starve_d;
  logic                   pend_q;
  logic [tag_width_p-1:0] tag_q;

  // Only the low address bits reach the write port, so only those are queued.
  if (waddr_width_p < word_size_p) begin : g_addr_trunc
    logic st_addr_hi_unused;
    assign st_addr_hi_unused = ^st_addr_i[word_size_p-1:waddr_width_p];
  end

  assign force_store = ~q_empty & (q_full | (starve_q == cnt_w_lp'(starve_limit_p)));
  assign store_wins  = ~reset_i & ~q_empty & (force_store | ~ld_v_i);
  assign ld_ready_o  = ~reset_i & ~flush_i & ~force_store;
  assign ld_issue    = ld_v_i & ld_ready_o;
  assign st_ready_o  = ~reset_i & ~q_full;
  assign st_accept   = st_v_i & st_ready_o;

  dmem_store_queue #(
    .els_p  (store_q_els_p),
    .width_p(entry_w_lp)
  ) u_store_q (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .enq_i  (st_accept),
    .data_i ({st_addr_i[waddr_width_p-1:0], st_data_i}),
    .deq_i  (store_wins),
    .data_o (q_head),
    .full_o (q_full),
    .empty_o(q_empty)
  );

  assign data_mem_w_v_i    = store_wins;
  assign data_mem_w_addr_i = q_head[word_size_p +: waddr_width_p];
  assign data_mem_w_data_i = q_head[word_size_p-1:0];
  assign data_mem_r_v_i    = ld_issue;
  assign data_mem_r_addr_i = ld_addr_i;

  // Counts consecutive loads taken while a store waits; saturates at the limit.
  always_comb begin
    starve_d = starve_q;
    if (q_empty || store_wins) begin
      starve_d = '0;
    end else if (ld_issue && (starve_q != cnt_w_lp'(starve_limit_p))) begin
      starve_d = starve_q + cnt_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      starve_q <= '0;
      pend_q   <= 1'b0;
      tag_q    <= '0;
    end else begin
      starve_q <= starve_d;
      pend_q   <= ld_issue;
      if (ld_issue) tag_q <= ld_tag_i;
    end
  end

  assign ld_resp_v_o    = pend_q & ~flush_i;
  assign ld_resp_data_o = data_mem_r_data_o;
  assign ld_resp_tag_o  = tag_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized and directed bench for dmem_port_arbiter against a queue-based reference model.
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  localparam int W   = 16;
  localparam int AW  = 4;
  localparam int TW  = 4;
  localparam int LIM = 4;
  localparam int ELS = 2;

  logic          clk = 1'b0;
  logic          reset_i, flush_i;
  logic          st_v_i, ld_v_i;
  logic [W-1:0]  st_addr_i, st_data_i, ld_addr_i;
  logic [TW-1:0] ld_tag_i;
  logic          st_ready_o, ld_ready_o, ld_resp_v_o;
  logic [W-1:0]  ld_resp_data_o;
  logic [TW-1:0] ld_resp_tag_o;
  logic          w_v, r_v;
  logic [AW-1:0] w_addr;
  logic [W-1:0]  w_data, r_addr, r_data;

  always #5 clk = ~clk;

  dmem_port_arbiter dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .flush_i          (flush_i),
    .st_v_i           (st_v_i),
    .st_addr_i        (st_addr_i),
    .st_data_i        (st_data_i),
    .st_ready_o       (st_ready_o),
    .ld_v_i           (ld_v_i),
    .ld_addr_i        (ld_addr_i),
    .ld_tag_i         (ld_tag_i),
    .ld_ready_o       (ld_ready_o),
    .ld_resp_v_o      (ld_resp_v_o),
    .ld_resp_data_o   (ld_resp_data_o),
    .ld_resp_tag_o    (ld_resp_tag_o),
    .data_mem_w_v_i   (w_v),
    .data_mem_w_addr_i(w_addr),
    .data_mem_w_data_i(w_data),
    .data_mem_r_v_i   (r_v),
    .data_mem_r_addr_i(r_addr),
    .data_mem_r_data_o(r_data)
  );

  // Behavioural single-port memory attached to the DUT.
  logic [W-1:0] tb_mem [16];
  logic         mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) tb_mem[i] <= '0;
      r_data <= '0;
    end else begin
      if (w_v) tb_mem[w_addr] <= w_data;
      if (r_v) r_data <= tb_mem[r_addr[3:0]];
    end
  end

  // Reference model state
  dmem_store_entry_s sq[$];
  int                starve_m;
  bit                pend_m;
  logic [TW-1:0]     ptag_m;
  logic [W-1:0]      pdata_m;
  logic [W-1:0]      mem_m [16];

  int n_checks = 0;
  int n_fail   = 0;

  logic obs_st_ready, obs_ld_ready, obs_w_v, obs_r_v, obs_resp_v;
  logic [AW-1:0] obs_w_addr;
  logic [W-1:0]  obs_w_data, obs_resp_data;
  logic [TW-1:0] obs_resp_tag;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive, compare at negedge, advance the model, then cross the posedge.
  task automatic step(input bit sv, input logic [W-1:0] sa, input logic [W-1:0] sd,
                      input bit lv, input logic [W-1:0] la, input logic [TW-1:0] lt,
                      input bit fl);
    bit full, ne, forced, e_w, e_ldr, e_r, e_resp;
    st_v_i = sv; st_addr_i = sa; st_data_i = sd;
    ld_v_i = lv; ld_addr_i = la; ld_tag_i = lt; flush_i = fl;
    @(negedge clk);
    full   = (sq.size() == ELS);
    ne     = (sq.size() != 0);
    forced = ne && (full || starve_m == LIM);
    e_w    = ne && (forced || !lv);
    e_ldr  = !fl && !forced;
    e_r    = lv && e_ldr;
    e_resp = pend_m && !fl;
    check_eq("st_ready", st_ready_o, full ? 0 : 1);
    check_eq("ld_ready", ld_ready_o, e_ldr);
    check_eq("mem_w_v", w_v, e_w);
    check_eq("mem_r_v", r_v, e_r);
    check_eq("resp_v", ld_resp_v_o, e_resp);
    check_eq("w_r_excl", w_v & r_v, 0);
    if (e_w) begin
      check_eq("w_addr", w_addr, sq[0].addr[3:0]);
      check_eq("w_data", w_data, sq[0].data);
    end
    if (e_r) check_eq("r_addr", r_addr, la);
    if (e_resp) begin
      check_eq("resp_data", ld_resp_data_o, pdata_m);
      check_eq("resp_tag", ld_resp_tag_o, ptag_m);
    end
    obs_st_ready = st_ready_o; obs_ld_ready = ld_ready_o;
    obs_w_v = w_v; obs_r_v = r_v; obs_resp_v = ld_resp_v_o;
    obs_w_addr = w_addr; obs_w_data = w_data;
    obs_resp_data = ld_resp_data_o; obs_resp_tag = ld_resp_tag_o;
    if (e_w || e_r || e_resp || (sv && !full))
      $display("[%0t] st_acc=%0d wr=%0d rd=%0d resp=%0d qsize=%0d starve=%0d",
               $time, sv && !full, e_w, e_r, e_resp, sq.size(), starve_m);
    if (!ne || e_w) starve_m = 0;
    else if (e_r && starve_m < LIM) starve_m++;
    if (e_w) begin
      mem_m[sq[0].addr[3:0]] = sq[0].data;
      void'(sq.pop_front());
    end
    if (sv && !full) sq.push_back('{addr: sa, data: sd});
    pend_m = e_r;
    if (e_r) begin
      ptag_m  = lt;
      pdata_m = mem_m[la[3:0]];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, '0, '0, 0, '0, '0, 0);
  endtask

  // Asserts reset away from a clock edge, checks outputs collapse at once, releases at negedge.
  task automatic do_reset(input string tag);
    reset_i = 1'b1;
    st_v_i = 1'b1; ld_v_i = 1'b1; flush_i = 1'b0;
    #1;
    check_eq({tag, "_st_ready"}, st_ready_o, 0);
    check_eq({tag, "_ld_ready"}, ld_ready_o, 0);
    check_eq({tag, "_w_v"}, w_v, 0);
    check_eq({tag, "_r_v"}, r_v, 0);
    check_eq({tag, "_resp_v"}, ld_resp_v_o, 0);
    sq.delete();
    starve_m = 0;
    pend_m   = 0;
    @(posedge clk);
    #1;
    check_eq({tag, "_w_v_hold"}, w_v, 0);
    check_eq({tag, "_resp_v_hold"}, ld_resp_v_o, 0);
    @(negedge clk);
    st_v_i = 1'b0; ld_v_i = 1'b0;
    reset_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    starve_m = 0; pend_m = 0; ptag_m = '0; pdata_m = '0;
    mem_clr = 1'b1;
    flush_i = 0; st_v_i = 0; ld_v_i = 0;
    st_addr_i = '0; st_data_i = '0; ld_addr_i = '0; ld_tag_i = '0;
    reset_i = 1'b0;
    @(posedge clk);
    #1;
    do_reset("rst0");
    mem_clr = 1'b0;

    // Store then read it back
    step(1, 16'h0003, 16'hBEEF, 0, '0, '0, 0);
    check_eq("tp1_st_ready_after_rst", obs_st_ready, 1);
    idle();
    check_eq("tp1_w_v", obs_w_v, 1);
    check_eq("tp1_w_addr", obs_w_addr, 3);
    check_eq("tp1_w_data", obs_w_data, 16'hBEEF);
    step(0, '0, '0, 1, 16'h0003, 4'd5, 0);
    idle();
    check_eq("tp1_resp_v", obs_resp_v, 1);
    check_eq("tp1_resp_data", obs_resp_data, 16'hBEEF);
    check_eq("tp1_resp_tag", obs_resp_tag, 5);

    // Bounded starvation: four loads win, the fifth cycle goes to the store
    step(1, 16'h0007, 16'h1234, 1, 16'h0001, 4'd1, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, '0, '0, 1, W'(i), TW'(i), 0);
      if (i < 4) check_eq("tp2_load_wins", obs_r_v, 1);
      else begin
        check_eq("tp2_store_wins", obs_w_v, 1);
        check_eq("tp2_ld_blocked", obs_ld_ready, 0);
      end
    end
    idle();

    // Full queue forces stores and blocks loads and new stores
    step(1, 16'h0001, 16'hAAAA, 1, 16'h0002, 4'd2, 0);
    step(1, 16'h0002, 16'hBBBB, 1, 16'h0003, 4'd3, 0);
    step(1, 16'h0004, 16'hCCCC, 1, 16'h0004, 4'd4, 0);
    check_eq("tp3_st_ready_full", obs_st_ready, 0);
    check_eq("tp3_ld_ready_full", obs_ld_ready, 0);
    check_eq("tp3_w_v_full", obs_w_v, 1);
    for (int i = 0; i < 6; i++) step(0, '0, '0, 1, 16'h0001, 4'd6, 0);
    idle();
    check_eq("tp3_st_ready_drained", obs_st_ready, 1);

    // Flush squashes the pending response and blocks issue; the store still writes
    step(1, 16'h0005, 16'h5555, 1, 16'h0001, 4'd7, 0);
    step(0, '0, '0, 0, 16'h0002, 4'd8, 1);
    check_eq("tp4_resp_squashed", obs_resp_v, 0);
    check_eq("tp4_no_read", obs_r_v, 0);
    check_eq("tp4_store_writes", obs_w_v, 1);
    idle();

    // Reset mid-operation with a full queue and a pending load
    step(1, 16'h0008, 16'h8888, 0, '0, '0, 0);
    step(1, 16'h0009, 16'h9999, 1, 16'h0003, 4'd9, 0);
    do_reset("rst1");
    idle();
    check_eq("tp6_no_write", obs_w_v, 0);
    check_eq("tp6_st_ready", obs_st_ready, 1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset("rst_rand");
      step(bit'($urandom_range(0, 1)), W'($urandom), W'($urandom),
           bit'($urandom_range(0, 3) != 0), W'($urandom), TW'($urandom),
           bit'($urandom_range(0, 7) == 0));
    end
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
